// File: rtl/sram_pkg.sv
// Shared types and timing defaults for the asynchronous SRAM bus responder.
package sram_pkg;

    localparam int RAM_ADDRESS_WIDTH  = 20;
    localparam int READ_WAIT_DEFAULT  = 1;
    localparam int WRITE_WAIT_DEFAULT = 2;
    localparam logic [3:0] BE_NONE    = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_DONE
    } sram_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bus_if.sv
// Single-word data bus between the CPU and its memory-mapped responders.
interface Bus_if #(
    parameter int ADDR_WIDTH = 20
);
    logic [ADDR_WIDTH-1:0] address;
    logic [31:0]           data_wr;
    logic [3:0]            mask;
    logic                  read;
    logic                  write;
    logic [31:0]           data_rd;
    logic [31:0]           data_rd_2;
    logic                  stall;
    logic                  interrupt;

    modport slave (
        input  address, data_wr, mask, read, write,
        output data_rd, data_rd_2, stall, interrupt
    );

    modport master (
        output address, data_wr, mask, read, write,
        input  data_rd, data_rd_2, stall, interrupt
    );
endinterface

// File: rtl/sram_controller.sv
// Turns single-word bus reads/writes into timed asynchronous SRAM pin sequences,
// stalling the bus until the access has finished.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a request; stall follows read|write directly
// READ     | CE/OE low for READ_WAIT+1 cycles, data sampled on the last
// WR_SETUP | address/data/BE set up, WE still high
// WR_PULSE | WE low for WRITE_WAIT cycles
// WR_HOLD  | WE back high, data still driven
// DONE     | stall released, read data presented for one cycle
module sram_controller
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDRESS_WIDTH,
    parameter int READ_WAIT  = READ_WAIT_DEFAULT,
    parameter int WRITE_WAIT = WRITE_WAIT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    Bus_if.slave                  bus,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    inout  wire  [31:0]           sram_data,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [3:0]            sram_be_n
);

    localparam int CNT_W = $clog2(max_int(READ_WAIT, WRITE_WAIT) + 1);

    sram_state_t           state, next_state, st;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            mask_q;
    logic [31:0]           rdata;
    logic                  was_read;
    logic                  latch;
    logic                  sample;
    logic                  drive;

    // Reset forces the pins to their idle levels in the same cycle, not one edge later.
    always_comb begin
        st         = rst ? ST_IDLE : state;
        next_state = state;
        cnt_next   = cnt;
        latch      = 1'b0;
        sample     = 1'b0;
        drive      = 1'b0;
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_be_n  = BE_NONE;
        bus.stall  = 1'b0;
        bus.data_rd = '0;
        case (st)
            ST_IDLE: begin
                bus.stall = bus.read | bus.write;
                if (bus.write) begin
                    latch      = 1'b1;
                    next_state = (bus.mask == 4'h0) ? ST_DONE : ST_WR_SETUP;
                end else if (bus.read) begin
                    latch      = 1'b1;
                    next_state = ST_READ;
                    cnt_next   = CNT_W'(READ_WAIT);
                end
            end
            ST_READ: begin
                bus.stall = 1'b1;
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                sram_be_n = 4'h0;
                if (cnt == '0) begin
                    sample     = 1'b1;
                    next_state = ST_DONE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ST_WR_SETUP: begin
                bus.stall  = 1'b1;
                sram_ce_n  = 1'b0;
                sram_be_n  = ~mask_q;
                drive      = 1'b1;
                next_state = ST_WR_PULSE;
                cnt_next   = CNT_W'(WRITE_WAIT - 1);
            end
            ST_WR_PULSE: begin
                bus.stall = 1'b1;
                sram_ce_n = 1'b0;
                sram_we_n = 1'b0;
                sram_be_n = ~mask_q;
                drive     = 1'b1;
                if (cnt == '0) begin
                    next_state = ST_WR_HOLD;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ST_WR_HOLD: begin
                bus.stall  = 1'b1;
                sram_ce_n  = 1'b0;
                sram_be_n  = ~mask_q;
                drive      = 1'b1;
                next_state = ST_DONE;
            end
            ST_DONE: begin
                bus.data_rd = was_read ? rdata : 32'h0;
                next_state  = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            rdata    <= '0;
            was_read <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mask_q   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            if (latch) begin
                addr_q   <= bus.address;
                wdata_q  <= bus.data_wr;
                mask_q   <= bus.mask;
                was_read <= ~bus.write;
            end
            if (sample) begin
                rdata <= sram_data;
            end
        end
    end

    assign sram_addr     = addr_q;
    assign sram_data     = drive ? wdata_q : 'z;
    assign bus.data_rd_2 = '0;
    assign bus.interrupt = 1'b0;

endmodule

// File: doc/sram_controller.md
# sram_controller

Bus responder for the on-board asynchronous SRAM: it sits on the RAM port of the data bus and turns single-word bus reads and writes into timed SRAM pin sequences. It holds `bus.stall` high until the access has completed. Accesses are one word at a time, with byte enables taken from `bus.mask`. No burst or second-word support.

## Interface
Parameters:
- `ADDR_WIDTH`, default `RAM_ADDRESS_WIDTH` (20): word-address width.
- `READ_WAIT`, default 1: extra cycles with OE asserted before data is sampled (≥0).
- `WRITE_WAIT`, default 2: cycles with WE asserted (≥1).

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: synchronous, active-high reset.
- `bus`  Bus_if.slave: `address[ADDR_WIDTH-1:0]`, `data_wr[31:0]`, `mask[3:0]`, `read`, `write` in; `data_rd[31:0]`, `data_rd_2[31:0]`, `stall`, `interrupt` out.
- `sram_addr`  out  ADDR_WIDTH: word address.
- `sram_data`  inout  32: bidirectional data.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1: active-low controls.
- `sram_be_n`  out  4: active-low byte enables.

## Operation
- States: IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE behaviour:
  - `stall = read | write`, combinational, so it is high in the request cycle itself.
  - On a request, latch address, data and mask.
  - If `write` is high, go to WR_SETUP. A write wins when `read` and `write` are both high.
  - Otherwise, if `read` is high, go to READ.
- READ:
  - Drive address, CE=0, OE=0, all BE=0.
  - Stay READ_WAIT+1 cycles.
  - Register `sram_data` into `rdata` on the last cycle, then go to DONE.
- WR_SETUP (1 cycle): drive address and data, CE=0, BE=~mask, WE=1.
- WR_PULSE (WRITE_WAIT cycles): as WR_SETUP, with WE=0.
- WR_HOLD (1 cycle): WE=1, data still driven. Then go to DONE.
- Write with `mask==0`: go IDLE→DONE directly; no SRAM pins toggle.
- DONE (1 cycle): `stall=0`, `data_rd=rdata` (only after a read; 0 after a write). Next state is IDLE.
- `sram_data` is driven only in WR_SETUP, WR_PULSE and WR_HOLD; high-Z otherwise.
- In IDLE and DONE: CE=OE=WE=1, BE=4'hF.
- `data_rd_2` and `interrupt` are tied to 0.
- `data_rd` is 0 in every state except DONE after a read.
- Wait counter: `$clog2(max(READ_WAIT,WRITE_WAIT)+1)` bits. Loaded on state entry, decremented, no wrap.

## Timing
- Reset values: state IDLE, counter 0, `rdata` 0, all SRAM controls deasserted, `sram_data` high-Z, `stall` = IDLE rule.
- Read in cycle 0:
  - `stall` is high for cycles 0..READ_WAIT+1.
  - DONE falls in cycle READ_WAIT+2, with `stall=0` and data valid.
  - Total latency READ_WAIT+3 cycles.
- Write in cycle 0:
  - `stall` is high for cycles 0..WRITE_WAIT+2.
  - DONE falls in cycle WRITE_WAIT+3.
  - Total latency WRITE_WAIT+4 cycles.
- The CPU holds request signals stable while `stall=1`. The controller uses its latched copies regardless.
- A request held in the DONE cycle is consumed by the CPU. A new request seen in the following IDLE cycle starts a new access, so there is no back-to-back gap beyond IDLE.
- Reset mid-operation:
  - Next edge returns to IDLE.
  - WE/OE/CE go high and `sram_data` goes high-Z in that same cycle.
  - A still-asserted request restarts from IDLE.
- A request dropped while stalled (protocol violation) still completes the access. The DONE cycle is then ignored.

## Structure
- Package `sram_pkg`: `sram_state_t` enum, default timing constants, and the `BE_NONE` (4'hF) constant.
- Tristate handled in the module itself via `sram_data = drive ? wdata : 'z`.
- No sub-module; a single FSM plus counter.

## Test plan
- Reset: `rst` held 3 cycles with `read=1` → CE/OE/WE=1, `sram_data` = Z, `stall=1`. After release, the read completes normally.
- Read, READ_WAIT=1, address 0x00123:
  - SRAM model returns 0xDEADBEEF.
  - `stall` is high for cycles 0–2; cycle 3 has `stall=0` and `data_rd=0xDEADBEEF`.
  - `sram_addr=0x00123` while OE=0.
- Write, WRITE_WAIT=2, address 0x00040, data 0x11223344, mask 4'b0101:
  - WE low for exactly 2 cycles, `sram_be_n=4'b1010`.
  - Model bytes 0 and 2 change to 0x44/0x22; bytes 1 and 3 are unchanged.
  - DONE in cycle 5.
- Write with mask 0 → `stall` high for one cycle, no CE/WE activity, DONE in cycle 1.
- `read` and `write` both high → write sequence is performed, `data_rd=0` in DONE.
- Back-to-back write then read to the same address → read returns the written data. `sram_data` is never driven by both sides in any cycle (bench checks for X).
